// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller: shadow EXE/MEM/WB destination slots, load-use stall, branch flush, operand forwarding selects.
// Latency: stall/flush combinational in the same cycle; forwarding selects registered on the edge an instruction enters execute.
// Backpressure: downstream stages never stall; a load-use hazard holds fetch/decode and injects a bubble into execute.
// Optional statistics counters are built when HAZARD_STATS_EN is defined.
module hazard_ctrl #(
    parameter int REG_W  = 4,
    parameter int PC_REG = 15,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             deco_valid,
    input  logic [REG_W-1:0] deco_rn,
    input  logic [REG_W-1:0] deco_rm,
    input  logic             deco_use_rn,
    input  logic             deco_use_rm,
    input  logic             deco_wr_en,
    input  logic [REG_W-1:0] deco_rd,
    input  logic             deco_is_load,
    input  logic             branch_taken,
    output logic             stall,
    output logic             flush_fd,
    output logic             flush_de,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel
`ifdef HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    localparam logic [REG_W-1:0] PC_IDX = REG_W'(PC_REG);

    localparam logic [1:0] SEL_RF  = 2'd0;
    localparam logic [1:0] SEL_MEM = 2'd1;
    localparam logic [1:0] SEL_WB  = 2'd2;

    typedef struct packed {
        logic             valid;
        logic             wr_en;
        logic [REG_W-1:0] rd;
        logic             is_load;
    } slot_t;

    slot_t      exe_q, exe_d;
    slot_t      mem_q, mem_d;
    slot_t      wb_q,  wb_d;
    logic [1:0] fwd_a_q, fwd_a_d;
    logic [1:0] fwd_b_q, fwd_b_d;
    logic       enter_exe;

    // A source depends on a slot when that slot writes it, the source is read, and it is not the PC.
    function automatic logic src_match(input slot_t s, input logic [REG_W-1:0] src,
                                       input logic use_bit);
        return s.valid & s.wr_en & (s.rd == src) & (src != PC_IDX) & use_bit;
    endfunction

    // Newest producer wins; a load still in EXE has no result yet, so it never yields the MEM path.
    function automatic logic [1:0] fwd_sel(input slot_t exe, input slot_t mem,
                                           input logic [REG_W-1:0] src, input logic use_bit);
        if (src_match(exe, src, use_bit) && !exe.is_load) begin
            return SEL_MEM;
        end else if (src_match(mem, src, use_bit)) begin
            return SEL_WB;
        end
        return SEL_RF;
    endfunction

    // Hazard outputs: load-use stall yields to a taken branch; flush only outside reset.
    always_comb begin
        stall    = deco_valid & ~branch_taken & exe_q.is_load &
                   (src_match(exe_q, deco_rn, deco_use_rn) | src_match(exe_q, deco_rm, deco_use_rm));
        flush_fd = branch_taken & ~rst;
        flush_de = branch_taken & ~rst;
    end

    // Next shadow-pipeline state and forwarding selects for the instruction entering execute.
    always_comb begin
        enter_exe = deco_valid & ~branch_taken & ~stall;
        exe_d     = '0;
        mem_d     = exe_q;
        wb_d      = mem_q;
        fwd_a_d   = SEL_RF;
        fwd_b_d   = SEL_RF;
        if (enter_exe) begin
            exe_d.valid   = 1'b1;
            exe_d.wr_en   = deco_wr_en;
            exe_d.rd      = deco_rd;
            exe_d.is_load = deco_is_load;
            fwd_a_d       = fwd_sel(exe_q, mem_q, deco_rn, deco_use_rn);
            fwd_b_d       = fwd_sel(exe_q, mem_q, deco_rm, deco_use_rm);
        end
    end

    // Shadow slots and forwarding selects; reset empties every slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            exe_q   <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            fwd_a_q <= SEL_RF;
            fwd_b_q <= SEL_RF;
        end else begin
            exe_q   <= exe_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign fwd_a_sel = fwd_a_q;
    assign fwd_b_sel = fwd_b_q;

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating event counters for stall cycles and taken branches.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (branch_taken && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed per-cycle vectors with hand-computed expectations pushed to a scoreboard.
// Latency: each row's expectation covers the cycle the row is driven (selects reflect the previous row's entry).
// Backpressure: none; a negedge monitor pops one expectation per driven row.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic       deco_valid;
    logic [3:0] deco_rn;
    logic [3:0] deco_rm;
    logic       deco_use_rn;
    logic       deco_use_rm;
    logic       deco_wr_en;
    logic [3:0] deco_rd;
    logic       deco_is_load;
    logic       branch_taken;
    logic       stall;
    logic       flush_fd;
    logic       flush_de;
    logic [1:0] fwd_a_sel;
    logic [1:0] fwd_b_sel;
`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
`endif

    typedef struct {
        int         id;
        logic       stall;
        logic       flush;
        logic [1:0] fa;
        logic [1:0] fb;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    hazard_ctrl #(.REG_W(4), .PC_REG(15), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .deco_valid   (deco_valid),
        .deco_rn      (deco_rn),
        .deco_rm      (deco_rm),
        .deco_use_rn  (deco_use_rn),
        .deco_use_rm  (deco_use_rm),
        .deco_wr_en   (deco_wr_en),
        .deco_rd      (deco_rd),
        .deco_is_load (deco_is_load),
        .branch_taken (branch_taken),
        .stall        (stall),
        .flush_fd     (flush_fd),
        .flush_de     (flush_de),
        .fwd_a_sel    (fwd_a_sel),
        .fwd_b_sel    (fwd_b_sel)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int id, input logic [15:0] act,
                         input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, id, act, req);
        end
    endtask

    // Monitor: one expectation per driven row, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("stall",     e.id, 16'(stall),     16'(e.stall));
            check("flush_fd",  e.id, 16'(flush_fd),  16'(e.flush));
            check("flush_de",  e.id, 16'(flush_de),  16'(e.flush));
            check("fwd_a_sel", e.id, 16'(fwd_a_sel), 16'(e.fa));
            check("fwd_b_sel", e.id, 16'(fwd_b_sel), 16'(e.fb));
        end
    end

    task automatic drive(input logic r, input logic bt, input logic v,
                         input logic [3:0] rn, input logic [3:0] rm,
                         input logic urn, input logic urm, input logic wr,
                         input logic [3:0] rd, input logic ld);
        @(posedge clk);
        #1;
        rst          = r;
        branch_taken = bt;
        deco_valid   = v;
        deco_rn      = rn;
        deco_rm      = rm;
        deco_use_rn  = urn;
        deco_use_rm  = urm;
        deco_wr_en   = wr;
        deco_rd      = rd;
        deco_is_load = ld;
    endtask

    task automatic row(input int id, input logic r, input logic bt, input logic v,
                       input logic [3:0] rn, input logic [3:0] rm,
                       input logic urn, input logic urm, input logic wr,
                       input logic [3:0] rd, input logic ld,
                       input logic es, input logic ef, input logic [1:0] fa,
                       input logic [1:0] fb);
        exp_t e;
        drive(r, bt, v, rn, rm, urn, urm, wr, rd, ld);
        e.id = id; e.stall = es; e.flush = ef; e.fa = fa; e.fb = fb;
        exp_q.push_back(e);
    endtask

    initial begin
        rst = 1'b1; branch_taken = 1'b1; deco_valid = 1'b0;
        deco_rn = '0; deco_rm = '0; deco_use_rn = 1'b0; deco_use_rm = 1'b0;
        deco_wr_en = 1'b0; deco_rd = '0; deco_is_load = 1'b0;

        //   id  r bt v  rn  rm urn urm wr rd  ld   stall flush fa fb
        // reset held with branch_taken asserted
        row( 1, 1, 1, 1,  4,  4, 1, 1, 1,  5, 0,   0, 0, 0, 0);
        row( 2, 1, 1, 1,  4,  4, 1, 1, 1,  5, 0,   0, 0, 0, 0);
        row( 3, 0, 0, 0,  0,  0, 0, 0, 0,  0, 0,   0, 0, 0, 0);
        // ALU chain: ADD r1; SUB r2,r1,r3; reader of r1 two slots later; reader three slots later
        row( 4, 0, 0, 1,  2,  3, 1, 1, 1,  1, 0,   0, 0, 0, 0);
        row( 5, 0, 0, 1,  1,  3, 1, 1, 1,  2, 0,   0, 0, 0, 0);
        row( 6, 0, 0, 1,  1,  7, 1, 1, 1,  6, 0,   0, 0, 1, 0);
        row( 7, 0, 0, 1,  1,  2, 1, 1, 1, 11, 0,   0, 0, 2, 0);
        row( 8, 0, 0, 0,  0,  0, 0, 0, 0,  0, 0,   0, 0, 0, 2);
        // load-use: LDR r4; ADD r5,r4,r4 stalls once, then both selects from WB path
        row( 9, 0, 0, 1, 10,  0, 1, 0, 1,  4, 1,   0, 0, 0, 0);
        row(10, 0, 0, 1,  4,  4, 1, 1, 1,  5, 0,   1, 0, 0, 0);
        row(11, 0, 0, 1,  4,  4, 1, 1, 1,  5, 0,   0, 0, 0, 0);
        row(12, 0, 0, 0,  0,  0, 0, 0, 0,  0, 0,   0, 0, 2, 2);
        // priority: two writers of r1, newest wins; rm not read so no forward
        row(13, 0, 0, 1,  2,  3, 1, 1, 1,  1, 0,   0, 0, 0, 0);
        row(14, 0, 0, 1,  2,  3, 1, 1, 1,  1, 0,   0, 0, 0, 0);
        row(15, 0, 0, 1,  1,  1, 1, 0, 0,  0, 0,   0, 0, 0, 0);
        row(16, 0, 0, 0,  0,  0, 0, 0, 0,  0, 0,   0, 0, 1, 0);
        // branch in the same cycle as a load-use hazard
        row(17, 0, 0, 1, 10,  0, 1, 0, 1,  4, 1,   0, 0, 0, 0);
        row(18, 0, 1, 1,  4,  4, 1, 1, 1,  5, 0,   0, 1, 0, 0);
        row(19, 0, 0, 1,  4,  4, 1, 1, 1,  5, 0,   0, 0, 0, 0);
        row(20, 0, 0, 0,  0,  0, 0, 0, 0,  0, 0,   0, 0, 2, 2);
        // PC register: load to r15 then reader of r15
        row(21, 0, 0, 1,  0,  0, 0, 0, 1, 15, 1,   0, 0, 0, 0);
        row(22, 0, 0, 1, 15, 15, 1, 1, 1,  7, 0,   0, 0, 0, 0);
        row(23, 0, 0, 0,  0,  0, 0, 0, 0,  0, 0,   0, 0, 0, 0);
        // reset during a load-use stall
        row(24, 0, 0, 1, 10,  0, 1, 0, 1,  4, 1,   0, 0, 0, 0);
        row(25, 1, 0, 1,  4,  4, 1, 1, 1,  5, 0,   1, 0, 0, 0);
        row(26, 0, 0, 1,  4,  4, 1, 1, 1,  5, 0,   0, 0, 0, 0);
        row(27, 0, 0, 0,  0,  0, 0, 0, 0,  0, 0,   0, 0, 0, 0);
        // one more load-use stall after reset
        row(28, 0, 0, 1, 10,  0, 1, 0, 1,  4, 1,   0, 0, 0, 0);
        row(29, 0, 0, 1,  4,  4, 1, 1, 1,  5, 0,   1, 0, 0, 0);
        row(30, 0, 0, 0,  0,  0, 0, 0, 0,  0, 0,   0, 0, 0, 0);
        @(negedge clk);
        #1;
        check("scoreboard_drained", 0, 16'(exp_q.size()), 16'd0);

`ifdef HAZARD_STATS_EN
        check("stall_cnt_one", 0, stall_cnt, 16'd1);
        check("flush_cnt_zero", 0, flush_cnt, 16'd0);
        for (int i = 0; i < 65540; i++) begin
            drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        end
        @(negedge clk);
        check("flush_cnt_sat", 0, flush_cnt, 16'hFFFF);
        check("stall_cnt_hold", 0, stall_cnt, 16'd1);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("stall_cnt_rst", 0, stall_cnt, 16'd0);
        check("flush_cnt_rst", 0, flush_cnt, 16'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
